cpu_controller: RTL and testbench

Phase sequencer for the 8-bit accumulator CPU. It steps through an 8-phase instruction cycle and decodes the current opcode from the instruction register into the datapath control strobes. The datapath units it drives are the memory, program counter, instruction register, accumulator and the ALU. It consumes the ALU's `a_is_zero` flag (as `zero`) for SKZ, and it latches a halted state on HLT.

---
 rtl/cpu_controller.sv | 47 ++++
 tb/tb_cpu_controller.sv | 76 +++++++
 2 files changed

// File: rtl/cpu_controller.sv
// cpu_controller: 8-phase instruction sequencer and opcode decoder for the accumulator CPU
// Ports: clk/rst (sync, active-high); opcode (IR opcode) and zero (accumulator-is-zero) in;
// sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr strobes and debug phase out.
module cpu_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       halt,
  output logic       ld_pc,
  output logic       data_e,
  output logic       ld_ac,
  output logic       wr,
  output logic [2:0] phase
);
  typedef enum logic [2:0] {HLT, SKZ, ADD, AND_OP, XOR_OP, LDA, STO, JMP} op_t;
  logic halted;
  logic alu_op;
  logic is_hlt;
  always_ff @(posedge clk) begin
    if (rst) begin
      phase  <= 3'd0;
      halted <= 1'b0;
    end else if (!halted) begin
      if (phase == 3'd4 && is_hlt) halted <= 1'b1;
      else phase <= phase + 3'd1;
    end
  end
  always_comb begin
    alu_op = opcode inside {ADD, AND_OP, XOR_OP, LDA};
    is_hlt = opcode == HLT;
    sel    = !phase[2];
    rd     = (phase inside {3'd1, 3'd2, 3'd3}) || (phase inside {3'd5, 3'd6, 3'd7} && alu_op);
    ld_ir  = phase inside {3'd2, 3'd3};
    // halted parks in phase 4, so only the phase-4 decodes need the halted gate
    inc_pc = (phase == 3'd4 && !halted) || (phase == 3'd6 && opcode == SKZ && zero);
    halt   = halted || (phase == 3'd4 && is_hlt);
    ld_pc  = phase inside {3'd6, 3'd7} && opcode == JMP;
    data_e = phase inside {3'd6, 3'd7} && opcode == STO;
    ld_ac  = phase == 3'd7 && alu_op;
    wr     = phase == 3'd7 && opcode == STO;
  end
endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: directed scoreboard bench for cpu_controller
module tb_cpu_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] opcode = 3'd0;
  logic zero = 1'b0;
  logic sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr;
  logic [2:0] phase;
  int n_tests = 0;
  int n_fail = 0;
  logic [11:0] q[$];
  always #5 clk = ~clk;
  cpu_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .halt(halt),
    .ld_pc(ld_pc), .data_e(data_e), .ld_ac(ld_ac), .wr(wr), .phase(phase)
  );
  // vector bits: {phase[2:0], sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr}
  localparam logic [8:0] ADD_T[8]  = '{9'h100, 9'h180, 9'h1C0, 9'h1C0, 9'h020, 9'h080, 9'h080, 9'h082};
  localparam logic [8:0] SKZ1_T[8] = '{9'h100, 9'h180, 9'h1C0, 9'h1C0, 9'h020, 9'h000, 9'h020, 9'h000};
  localparam logic [8:0] SKZ0_T[8] = '{9'h100, 9'h180, 9'h1C0, 9'h1C0, 9'h020, 9'h000, 9'h000, 9'h000};
  localparam logic [8:0] STO_T[8]  = '{9'h100, 9'h180, 9'h1C0, 9'h1C0, 9'h020, 9'h000, 9'h004, 9'h005};
  localparam logic [8:0] JMP_T[8]  = '{9'h100, 9'h180, 9'h1C0, 9'h1C0, 9'h020, 9'h000, 9'h008, 9'h008};
  always @(negedge clk) begin
    logic [11:0] e;
    logic [11:0] got;
    if (q.size() > 0) begin
      e = q.pop_front();
      got = {phase, sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr};
      n_tests++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL out#%0d: got phase=%0d strobes=%b, expected phase=%0d strobes=%b",
                 n_tests, got[11:9], got[8:0], e[11:9], e[8:0]);
      end
    end
  end
  task automatic chk(input logic r, input logic [2:0] op, input logic z, input logic [8:0] v, input logic [2:0] ph);
    rst = r;
    opcode = op;
    zero = z;
    q.push_back({ph, v});
    @(posedge clk);
    #1;
  endtask
  task automatic run_instr(input logic [2:0] op, input logic z, input logic [8:0] t[8]);
    for (int p = 0; p < 8; p++) chk(1'b0, op, z, t[p], p[2:0]);
  endtask
  initial begin
    @(posedge clk);
    #1;
    run_instr(3'd2, 1'b0, ADD_T);
    run_instr(3'd1, 1'b1, SKZ1_T);
    run_instr(3'd1, 1'b0, SKZ0_T);
    run_instr(3'd6, 1'b1, STO_T);
    run_instr(3'd7, 1'b0, JMP_T);
    for (int p = 0; p < 6; p++) chk(1'b0, 3'd6, 1'b0, STO_T[p], p[2:0]);
    chk(1'b1, 3'd6, 1'b0, 9'h004, 3'd6);
    chk(1'b0, 3'd0, 1'b0, 9'h100, 3'd0);
    for (int p = 1; p < 4; p++) chk(1'b0, 3'd0, 1'b0, ADD_T[p], p[2:0]);
    chk(1'b0, 3'd0, 1'b0, 9'h030, 3'd4);
    for (int i = 0; i < 20; i++) chk(1'b0, (i % 2) ? 3'd2 : 3'd7, i[0], 9'h010, 3'd4);
    chk(1'b1, 3'd2, 1'b1, 9'h010, 3'd4);
    run_instr(3'd2, 1'b1, ADD_T);
    run_instr(3'd5, 1'b0, ADD_T);
    repeat (2) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d checks left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
